// File: rtl/zap_fetch_pkg.sv
// zap_fetch_pkg: shared state encoding and constants for the fetch feeder.
package zap_fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WR, DISCARD} state_t;
    localparam int WORD_INC = 4;
    localparam logic [3:0] SEL_ALL = 4'hF;
endpackage

// File: rtl/zap_fetch_feeder.sv
// zap_fetch_feeder: single-outstanding sequential instruction fetcher feeding the pipeline FIFO.
module zap_fetch_feeder
    import zap_fetch_pkg::*;
#(
    parameter int AW = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_redirect,
    input  logic [AW-1:0] i_redirect_pc,
    input  logic          i_fifo_full,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic [AW-1:0] o_wb_adr,
    output logic [3:0]    o_wb_sel,
    input  logic [31:0]   i_wb_dat,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    output logic          o_valid,
    output logic [31:0]   o_instr,
    output logic [AW-1:0] o_pc,
    output logic          o_abort
);
    localparam logic [AW-1:0] START_PC = {RESET_PC[AW-1:2], 2'b00};

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n, adr_n, opc_n;
    logic          cyc_n, valid_q, valid_n, abort_n;
    logic [31:0]   instr_n;
    logic [AW-1:0] target;

    assign target   = {i_redirect_pc[AW-1:2], 2'b00};
    assign o_wb_stb = o_wb_cyc;
    assign o_wb_sel = SEL_ALL;
    // A redirect during WR kills the registered strobe so a stale word never lands in the FIFO.
    assign o_valid  = valid_q & ~i_redirect;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            pc       <= START_PC;
            o_wb_cyc <= 1'b0;
            o_wb_adr <= START_PC;
            valid_q  <= 1'b0;
            o_instr  <= '0;
            o_pc     <= '0;
            o_abort  <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            o_wb_cyc <= cyc_n;
            o_wb_adr <= adr_n;
            valid_q  <= valid_n;
            o_instr  <= instr_n;
            o_pc     <= opc_n;
            o_abort  <= abort_n;
        end
    end

    // A redirect always reloads pc; only an accepted word advances it instead.
    always_comb begin
        state_n = state;
        pc_n    = i_redirect ? target : pc;
        cyc_n   = o_wb_cyc;
        adr_n   = o_wb_adr;
        valid_n = 1'b0;
        instr_n = o_instr;
        opc_n   = o_pc;
        abort_n = o_abort;
        case (state)
            IDLE: begin
                if (!i_redirect && !i_fifo_full) begin
                    cyc_n   = 1'b1;
                    adr_n   = pc;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (i_wb_ack) begin
                    cyc_n   = 1'b0;
                    state_n = i_redirect ? IDLE : WR;
                    if (!i_redirect) begin
                        valid_n = 1'b1;
                        instr_n = i_wb_dat;
                        opc_n   = o_wb_adr;
                        abort_n = i_wb_err;
                        pc_n    = o_wb_adr + AW'(WORD_INC);
                    end
                end else if (i_redirect) begin
                    state_n = DISCARD;
                end
            end
            WR: state_n = IDLE;
            DISCARD: begin
                if (i_wb_ack) begin
                    cyc_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
